// File: rtl/trb_pkg.sv
// -----------------------------------------------------------------------------
// trb_pkg
// Shared definitions for the trace-buffer capture sequencer slice.
//   TRB_ADDR_WIDTH : default ring pointer width
//   TRB_WIDTH      : default trace word width
//   TRB_DEPTH      : ring depth (2**TRB_ADDR_WIDTH); one slot stays unused so
//                    full and empty can be told apart
//   trb_seq_state_e: capture state machine encoding
//   sat_inc16      : 16-bit saturating increment
// -----------------------------------------------------------------------------
package trb_pkg;

  localparam int TRB_ADDR_WIDTH = 8;
  localparam int TRB_WIDTH      = 32;
  localparam int TRB_DEPTH      = 2 ** TRB_ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    POST   = 3'd2,
    DONE   = 3'd3,
    STREAM = 3'd4
  } trb_seq_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage : trb_pkg

// File: rtl/trb_ring_ptr.sv
// -----------------------------------------------------------------------------
// trb_ring_ptr
// Write/read pointer pair for the trace ring, wrapping naturally at
// 2**ADDR_WIDTH. Full is "write pointer plus one equals read pointer", so the
// usable capacity is DEPTH-1.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (pointers to 0)
//   clr         : rp := wp (discard all entries)
//   push        : write pointer advances
//   push_drop   : write pointer advances; when full the oldest entry is
//                 dropped by advancing the read pointer too
//   pop         : read pointer advances
//   wp, rp      : current write / read pointer
//   full, empty : occupancy flags from the current (pre-edge) pointers
// -----------------------------------------------------------------------------
module trb_ring_ptr
  import trb_pkg::*;
#(
  parameter int ADDR_WIDTH = TRB_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  push_drop,
  input  logic                  pop,
  output logic [ADDR_WIDTH-1:0] wp,
  output logic [ADDR_WIDTH-1:0] rp,
  output logic                  full,
  output logic                  empty
);

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] wp_r;
  logic [ADDR_WIDTH-1:0] rp_r;
  logic [ADDR_WIDTH-1:0] wp_inc_s;
  logic [ADDR_WIDTH-1:0] rp_inc_s;
  logic                  full_s;
  logic                  empty_s;

  assign wp_inc_s = wp_r + PTR_ONE;
  assign rp_inc_s = rp_r + PTR_ONE;
  assign full_s   = (wp_inc_s == rp_r);
  assign empty_s  = (wp_r == rp_r);

  // Pointer registers; clear has priority over any read-side advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_r <= {ADDR_WIDTH{1'b0}};
      rp_r <= {ADDR_WIDTH{1'b0}};
    end else begin
      if (push || push_drop) begin
        wp_r <= wp_inc_s;
      end else begin
        wp_r <= wp_r;
      end
      if (clr) begin
        rp_r <= wp_r;
      end else if (pop || (push_drop && full_s)) begin
        rp_r <= rp_inc_s;
      end else begin
        rp_r <= rp_r;
      end
    end
  end

  assign wp    = wp_r;
  assign rp    = rp_r;
  assign full  = full_s;
  assign empty = empty_s;

endmodule : trb_ring_ptr

// File: rtl/trb_capture_sequencer.sv
// -----------------------------------------------------------------------------
// trb_capture_sequencer
// Sequences the logger-side trace ring: owns the ring pointers and the logger
// write strobe and runs the capture state machine. Trigger mode keeps
// pre-trigger history, takes a post-trigger sample count, then freezes.
// Stream mode behaves as a backpressured FIFO. Pointers only move on logger
// turns (rw_turn = 0).
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   arm              : level, high arms capture, low returns to IDLE
//   mode             : 0 trigger mode, 1 stream mode (sampled when arming)
//   trg_event        : trigger pulse (only acted on in ARMED)
//   trg_delay        : post-trigger sample count, sampled at the trigger
//   trace_valid/data : offered trace sample
//   trace_ready      : sample accepted when trace_valid && trace_ready
//   rw_turn          : 0 = logger owns the memory this cycle
//   read_advance     : consumer pop request, held until read_ack
//   read_ack         : pop performed this cycle
//   write_ptr        : next write address; read_ptr: oldest valid entry
//   logger_write     : write strobe (equals accept), logger_data: write data
//   empty, full      : ring occupancy
//   triggered        : trigger seen since arm; done: capture frozen
//   overflow_cnt     : dropped/refused sample count
// Build option: TRB_SEQ_OVERFLOW_CNT_EN enables the 16-bit saturating
// overflow counter; otherwise overflow_cnt is tied to zero.
// -----------------------------------------------------------------------------
module trb_capture_sequencer
  import trb_pkg::*;
#(
  parameter int ADDR_WIDTH = TRB_ADDR_WIDTH,
  parameter int DATA_WIDTH = TRB_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  mode,
  input  logic                  trg_event,
  input  logic [ADDR_WIDTH-1:0] trg_delay,
  input  logic                  trace_valid,
  input  logic [DATA_WIDTH-1:0] trace_data,
  output logic                  trace_ready,
  input  logic                  rw_turn,
  input  logic                  read_advance,
  output logic                  read_ack,
  output logic [ADDR_WIDTH-1:0] write_ptr,
  output logic [ADDR_WIDTH-1:0] read_ptr,
  output logic                  logger_write,
  output logic [DATA_WIDTH-1:0] logger_data,
  output logic                  empty,
  output logic                  full,
  output logic                  triggered,
  output logic                  done,
  output logic [15:0]           overflow_cnt
);

  localparam logic [ADDR_WIDTH-1:0] CNT_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  trb_seq_state_e        state_r;
  logic [ADDR_WIDTH-1:0] cnt_r;
  logic                  triggered_r;

  logic                  capture_s;
  logic                  ready_s;
  logic                  accept_s;
  logic                  ack_s;
  logic                  arm_now_s;
  logic                  push_s;
  logic                  push_drop_s;
  logic [ADDR_WIDTH-1:0] wp_s;
  logic [ADDR_WIDTH-1:0] rp_s;
  logic                  full_s;
  logic                  empty_s;

  // Handshake decode from registered state and current pointers.
  always_comb begin
    capture_s   = (state_r == ARMED) || (state_r == POST);
    ready_s     = !rw_turn && (capture_s || ((state_r == STREAM) && !full_s));
    accept_s    = trace_valid && ready_s;
    ack_s       = read_advance && !rw_turn && !empty_s &&
                  ((state_r == STREAM) || (state_r == DONE));
    arm_now_s   = (state_r == IDLE) && arm;
    // Capture-mode writes overwrite the oldest entry when the ring is full.
    push_drop_s = accept_s && capture_s;
    push_s      = accept_s && (state_r == STREAM);
  end

  trb_ring_ptr #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ring_ptr (
    .clk       (clk),
    .rst       (rst),
    .clr       (arm_now_s),
    .push      (push_s),
    .push_drop (push_drop_s),
    .pop       (ack_s),
    .wp        (wp_s),
    .rp        (rp_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  // Capture state machine, post-trigger counter and trigger flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      triggered_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (arm) begin
            triggered_r <= 1'b0;
            state_r     <= mode ? STREAM : ARMED;
          end else begin
            state_r <= IDLE;
          end
        end
        ARMED: begin
          // Disarm wins over a trigger arriving in the same cycle.
          if (!arm) begin
            state_r <= IDLE;
          end else if (trg_event) begin
            triggered_r <= 1'b1;
            if (trg_delay == CNT_ZERO) begin
              state_r <= DONE;
            end else begin
              // The sample accepted alongside the trigger is not counted.
              cnt_r   <= trg_delay;
              state_r <= POST;
            end
          end else begin
            state_r <= ARMED;
          end
        end
        POST: begin
          if (!arm) begin
            state_r <= IDLE;
          end else if (accept_s) begin
            cnt_r <= cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
              state_r <= DONE;
            end else begin
              state_r <= POST;
            end
          end else begin
            state_r <= POST;
          end
        end
        DONE: begin
          if (!arm) begin
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        STREAM: begin
          if (!arm) begin
            state_r <= IDLE;
          end else begin
            state_r <= STREAM;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef TRB_SEQ_OVERFLOW_CNT_EN
  logic [15:0] ovf_cnt_r;
  logic        ovf_hit_s;

  // An overflow is a capture overwrite or a stream offer refused for fullness.
  always_comb begin
    ovf_hit_s = (push_drop_s && full_s) ||
                ((state_r == STREAM) && trace_valid && !rw_turn && full_s);
  end

  // Saturating overflow counter, restarted on every arm.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt_r <= 16'd0;
    end else if (arm_now_s) begin
      ovf_cnt_r <= 16'd0;
    end else if (ovf_hit_s) begin
      ovf_cnt_r <= sat_inc16(ovf_cnt_r);
    end else begin
      ovf_cnt_r <= ovf_cnt_r;
    end
  end

  assign overflow_cnt = ovf_cnt_r;
`else
  assign overflow_cnt = 16'd0;
`endif

  assign trace_ready  = ready_s;
  assign logger_write = accept_s;
  assign logger_data  = trace_data;
  assign read_ack     = ack_s;
  assign write_ptr    = wp_s;
  assign read_ptr     = rp_s;
  assign empty        = empty_s;
  assign full         = full_s;
  assign triggered    = triggered_r;
  assign done         = (state_r == DONE);

endmodule : trb_capture_sequencer

// File: tb/tb_trb_capture_sequencer.sv
// -----------------------------------------------------------------------------
// tb_trb_capture_sequencer
// Directed, table-driven bench for trb_capture_sequencer (ADDR_WIDTH=8,
// DATA_WIDTH=32) plus hand-written multi-cycle sequences.
// -----------------------------------------------------------------------------
module tb_trb_capture_sequencer;

  logic        clk;
  logic        rst;
  logic        arm;
  logic        mode;
  logic        trg_event;
  logic [7:0]  trg_delay;
  logic        trace_valid;
  logic [31:0] trace_data;
  logic        trace_ready;
  logic        rw_turn;
  logic        read_advance;
  logic        read_ack;
  logic [7:0]  write_ptr;
  logic [7:0]  read_ptr;
  logic        logger_write;
  logic [31:0] logger_data;
  logic        empty;
  logic        full;
  logic        triggered;
  logic        done;
  logic [15:0] overflow_cnt;

  int n_chk;
  int n_fail;

  trb_capture_sequencer #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .mode         (mode),
    .trg_event    (trg_event),
    .trg_delay    (trg_delay),
    .trace_valid  (trace_valid),
    .trace_data   (trace_data),
    .trace_ready  (trace_ready),
    .rw_turn      (rw_turn),
    .read_advance (read_advance),
    .read_ack     (read_ack),
    .write_ptr    (write_ptr),
    .read_ptr     (read_ptr),
    .logger_write (logger_write),
    .logger_data  (logger_data),
    .empty        (empty),
    .full         (full),
    .triggered    (triggered),
    .done         (done),
    .overflow_cnt (overflow_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst, arm, mode, trg;
    logic [7:0] dly;
    logic       valid, turn, adv;
    logic       e_ready, e_write, e_ack;
    logic [7:0] e_wp, e_rp;
    logic       e_empty, e_full, e_trig, e_done;
  } vec_t;

  localparam int NVEC = 18;
  vec_t tbl [NVEC];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; arm = 1'b0; mode = 1'b0; trg_event = 1'b0; trg_delay = 8'd0;
    trace_valid = 1'b0; trace_data = 32'd0; rw_turn = 1'b0; read_advance = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic arm_mode(input logic m);
    arm = 1'b1; mode = m;
    tick();
    mode = 1'b0;
  endtask

  int writes;
  int acks;
  int bad;

  initial begin
    n_chk = 0;
    n_fail = 0;

    //            rst   arm   mode  trg   dly    valid turn  adv   | rdy  wr   ack  | wp     rp     emp  full trig done
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd3, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd4, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd4, 8'd1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4, 8'd1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4, 8'd4, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd5, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd6, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd6, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd6, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd6, 8'd6, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd6, 8'd6, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd6, 8'd6, 1'b1, 1'b0, 1'b0, 1'b0};

    // Power-up reset and reset-state checks.
    do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset wp", 32'(write_ptr), 32'd0);
    chk("reset rp", 32'(read_ptr), 32'd0);
    chk("reset empty", 32'(empty), 32'd1);
    chk("reset full", 32'(full), 32'd0);
    chk("reset triggered", 32'(triggered), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset ready", 32'(trace_ready), 32'd0);
    chk("reset write", 32'(logger_write), 32'd0);
    chk("reset ack", 32'(read_ack), 32'd0);
    chk("reset ovf", 32'(overflow_cnt), 32'd0);

    // Table: comb outputs checked mid-cycle, state checked after the edge.
    for (int i = 0; i < NVEC; i++) begin
      rst = tbl[i].rst; arm = tbl[i].arm; mode = tbl[i].mode;
      trg_event = tbl[i].trg; trg_delay = tbl[i].dly;
      trace_valid = tbl[i].valid; rw_turn = tbl[i].turn; read_advance = tbl[i].adv;
      trace_data = 32'hC0DE_0000 + 32'(i);
      @(negedge clk);
      chk($sformatf("v%0d ready", i), 32'(trace_ready), 32'(tbl[i].e_ready));
      chk($sformatf("v%0d write", i), 32'(logger_write), 32'(tbl[i].e_write));
      chk($sformatf("v%0d ack", i), 32'(read_ack), 32'(tbl[i].e_ack));
      chk($sformatf("v%0d data", i), logger_data, 32'hC0DE_0000 + 32'(i));
      tick();
      chk($sformatf("v%0d wp", i), 32'(write_ptr), 32'(tbl[i].e_wp));
      chk($sformatf("v%0d rp", i), 32'(read_ptr), 32'(tbl[i].e_rp));
      chk($sformatf("v%0d empty", i), 32'(empty), 32'(tbl[i].e_empty));
      chk($sformatf("v%0d full", i), 32'(full), 32'(tbl[i].e_full));
      chk($sformatf("v%0d trig", i), 32'(triggered), 32'(tbl[i].e_trig));
      chk($sformatf("v%0d done", i), 32'(done), 32'(tbl[i].e_done));
    end

    // Reset in the middle of POST with wp = 40.
    do_reset();
    arm_mode(1'b0);
    trace_valid = 1'b1;
    repeat (39) tick();
    trg_event = 1'b1; trg_delay = 8'd100;
    tick();
    trg_event = 1'b0;
    chk("midpost wp", 32'(write_ptr), 32'd40);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midpost rst wp", 32'(write_ptr), 32'd0);
    chk("midpost rst rp", 32'(read_ptr), 32'd0);
    chk("midpost rst empty", 32'(empty), 32'd1);
    chk("midpost rst write", 32'(logger_write), 32'd0);
    chk("midpost rst ready", 32'(trace_ready), 32'd0);
    chk("midpost rst done", 32'(done), 32'd0);
    chk("midpost rst trig", 32'(triggered), 32'd0);

    // Turn gating in stream mode.
    do_reset();
    arm_mode(1'b1);
    trace_valid = 1'b1; rw_turn = 1'b1; writes = 0;
    repeat (10) begin
      @(negedge clk);
      if (logger_write) writes++;
      tick();
    end
    chk("turn writes", 32'(writes), 32'd0);
    chk("turn wp held", 32'(write_ptr), 32'd0);
    rw_turn = 1'b0;
    @(negedge clk);
    chk("turn write", 32'(logger_write), 32'd1);
    chk("turn addr", 32'(write_ptr), 32'd0);
    tick();
    chk("turn wp", 32'(write_ptr), 32'd1);

    // Stream fill to capacity, one pop, then a wrapping write.
    do_reset();
    arm_mode(1'b1);
    trace_valid = 1'b1; writes = 0;
    repeat (300) begin
      @(negedge clk);
      if (logger_write) writes++;
      tick();
    end
    chk("fill writes", 32'(writes), 32'd255);
    chk("fill full", 32'(full), 32'd1);
    chk("fill wp", 32'(write_ptr), 32'd255);
    chk("fill ready", 32'(trace_ready), 32'd0);
`ifdef TRB_SEQ_OVERFLOW_CNT_EN
    chk("fill ovf", 32'(overflow_cnt), 32'd45);
`else
    chk("fill ovf", 32'(overflow_cnt), 32'd0);
`endif
    trace_valid = 1'b0; read_advance = 1'b1;
    @(negedge clk);
    chk("fill ack", 32'(read_ack), 32'd1);
    tick();
    read_advance = 1'b0;
    chk("fill rp", 32'(read_ptr), 32'd1);
    chk("fill not full", 32'(full), 32'd0);
    trace_valid = 1'b1;
    @(negedge clk);
    chk("fill wrap write", 32'(logger_write), 32'd1);
    tick();
    chk("fill wrap wp", 32'(write_ptr), 32'd0);
    trace_valid = 1'b0;

    // Trigger capture: 300 accepts, trigger on the 300th, delay 10.
    do_reset();
    arm_mode(1'b0);
    trace_valid = 1'b1;
    repeat (299) tick();
    trg_event = 1'b1; trg_delay = 8'd10;
    tick();
    trg_event = 1'b0;
    chk("cap triggered", 32'(triggered), 32'd1);
    writes = 0;
    repeat (30) begin
      @(negedge clk);
      if (logger_write) writes++;
      tick();
    end
    chk("cap post writes", 32'(writes), 32'd10);
    chk("cap done", 32'(done), 32'd1);
    chk("cap wp", 32'(write_ptr), 32'd54);
    chk("cap rp", 32'(read_ptr), 32'd55);
`ifdef TRB_SEQ_OVERFLOW_CNT_EN
    chk("cap ovf", 32'(overflow_cnt), 32'd55);
`else
    chk("cap ovf", 32'(overflow_cnt), 32'd0);
`endif
    trace_valid = 1'b0;

    // Drain the frozen capture, alternating memory turns.
    read_advance = 1'b1; acks = 0; bad = 0;
    for (int c = 0; c < 600; c++) begin
      rw_turn = c[0];
      @(negedge clk);
      if (read_ack) acks++;
      if (read_ack && rw_turn) bad++;
      tick();
    end
    chk("drain acks", 32'(acks), 32'd255);
    chk("drain turn acks", 32'(bad), 32'd0);
    chk("drain empty", 32'(empty), 32'd1);
    chk("drain rp", 32'(read_ptr), 32'd54);
    rw_turn = 1'b0;
    @(negedge clk);
    chk("drain no ack", 32'(read_ack), 32'd0);
    tick();
    read_advance = 1'b0;

    // Zero post-trigger delay freezes on the next edge.
    do_reset();
    arm_mode(1'b0);
    trace_valid = 1'b1;
    repeat (5) tick();
    trg_event = 1'b1; trg_delay = 8'd0;
    tick();
    trg_event = 1'b0;
    chk("dly0 done", 32'(done), 32'd1);
    chk("dly0 ready", 32'(trace_ready), 32'd0);
    chk("dly0 wp", 32'(write_ptr), 32'd6);
    repeat (5) tick();
    chk("dly0 wp frozen", 32'(write_ptr), 32'd6);
    chk("dly0 no write", 32'(logger_write), 32'd0);
    trace_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_trb_capture_sequencer

// File: doc/trb_capture_sequencer.md
Name: trb_capture_sequencer

Overview:
Sequences the trace-buffer ring for the logger side of the memory controller. Owns the write and read pointers and the logger write strobe, and runs the capture state machine. Trigger mode keeps pre-trigger history, takes a post-trigger count, then freezes. Stream mode is a backpressured FIFO. All pointer updates occur only on logger-turn cycles (RW_TURN_I=0).

Parameters:
ADDR_WIDTH, TRB_ADDR_WIDTH (8), pointer width; DEPTH = 2**ADDR_WIDTH, usable capacity DEPTH-1
DATA_WIDTH, TRB_WIDTH (32), trace word width

Ports:
CLK_I  in  1  single clock
RST_I  in  1  reset: one clock; reset is synchronous and active-high
ARM_I  in  1  level; high arms capture, low disarms
MODE_I  in  1  0 = trigger mode, 1 = stream mode; sampled only on IDLE->armed transition
TRG_EVENT_I  in  1  trigger pulse
TRG_DELAY_I  in  ADDR_WIDTH  post-trigger sample count; sampled at trigger
TRACE_VALID_I  in  1  trace sample offered
TRACE_DATA_I  in  DATA_WIDTH  trace sample
TRACE_READY_O  out  1  sample accepted this cycle when VALID&&READY
RW_TURN_I  in  1  from memory controller; 0 = logger turn
READ_ADVANCE_I  in  1  consumer request to pop one entry; held until ACK
READ_ACK_O  out  1  pop performed this cycle
WRITE_PTR_O  out  ADDR_WIDTH  next write address
READ_PTR_O  out  ADDR_WIDTH  oldest valid entry
LOGGER_WRITE_O  out  1  write strobe to memory controller
LOGGER_DATA_O  out  DATA_WIDTH  write data
EMPTY_O / FULL_O  out  1 each  rp==wp / (wp+1)%DEPTH==rp
TRIGGERED_O  out  1  trigger seen since arm
DONE_O  out  1  capture frozen
OVERFLOW_CNT_O  out  16  see Optional Feature

Behaviour:
- Reset (next edge, from any state): state IDLE, wp=rp=0, delay counter 0, TRIGGERED_O=0. All outputs 0 except EMPTY_O=1.
- States: IDLE, ARMED, POST, DONE, STREAM.
- IDLE + ARM_I: rp:=wp (buffer cleared). Go to ARMED if MODE_I=0, else STREAM.
- ARM_I low in ARMED/POST/STREAM/DONE -> IDLE; pointers held. ARM_I low beats a simultaneous trigger.
- Accept = TRACE_VALID_I && TRACE_READY_O.
- TRACE_READY_O = !RW_TURN_I && (state in {ARMED, POST} || (state==STREAM && !FULL_O)).
- LOGGER_WRITE_O = accept (combinational). LOGGER_DATA_O = TRACE_DATA_I. The write goes to the current WRITE_PTR_O; wp increments mod DEPTH at that edge (zero latency).
- ARMED/POST when full: an accept also increments rp, dropping the oldest entry. The ring always holds the newest DEPTH-1 samples.
- ARMED + TRG_EVENT_I:
  - TRIGGERED_O:=1.
  - A sample accepted in the same cycle is the trigger sample and is not counted.
  - TRG_DELAY_I==0 -> DONE; otherwise counter:=TRG_DELAY_I and go to POST.
- POST: each accept decrements the counter. The accept that takes it 1->0 moves to DONE. Further triggers are ignored.
- DONE: DONE_O=1, TRACE_READY_O=0, wp frozen.
- READ_ACK_O = READ_ADVANCE_I && !RW_TURN_I && !EMPTY_O && state in {STREAM, DONE}. An ACK increments rp mod DEPTH.
- STREAM: a simultaneous accept and ACK moves both pointers; FULL_O and EMPTY_O are evaluated on pre-edge values.
- TRG_EVENT_I is ignored in IDLE, STREAM and DONE.
- Pointer arithmetic is mod DEPTH with natural ADDR_WIDTH wrap (255+1 -> 0).

Optional Feature:
- Macro: TRB_SEQ_OVERFLOW_CNT_EN.
- Defined: OVERFLOW_CNT_O is a 16-bit saturating counter, cleared on reset and on arm. It increments on:
  - each ARMED/POST accept that overwrites when full;
  - each STREAM cycle with TRACE_VALID_I=1, RW_TURN_I=0 and FULL_O=1.
- Undefined: OVERFLOW_CNT_O is tied to 0; no counter logic.

Decomposition:
- Package trb_pkg: TRB_ADDR_WIDTH, TRB_WIDTH, TRB_DEPTH, enum trb_seq_state_e {IDLE, ARMED, POST, DONE, STREAM}.
- Sub-module trb_ring_ptr: wp/rp registers, mod-DEPTH increment, FULL/EMPTY, with push, pop and push-with-drop inputs.

Test Plan:
- Reset: RST_I=1 mid-POST (wp=40) -> next edge: state IDLE, WRITE_PTR_O=0, READ_PTR_O=0, EMPTY_O=1, LOGGER_WRITE_O=0, DONE_O=0.
- Turn gating: STREAM, VALID=1 with RW_TURN_I=1 for 10 cycles -> LOGGER_WRITE_O=0, pointers unchanged. RW_TURN_I=0 for one cycle -> exactly one write at address 0, WRITE_PTR_O=1.
- Stream fill (ADDR_WIDTH=8): 300 offers on logger turns -> 255 written, FULL_O=1, WRITE_PTR_O=255, READY=0. One READ_ACK -> READ_PTR_O=1, FULL_O=0, next offer accepted with WRITE_PTR_O wrapping to 0.
- Trigger capture: MODE_I=0, 300 accepts, trigger on the 300th with TRG_DELAY_I=10 -> exactly 10 more writes, DONE_O=1, WRITE_PTR_O=54, READ_PTR_O=55. With the macro, OVERFLOW_CNT_O=55.
- TRG_DELAY_I=0: trigger -> DONE next edge, TRACE_READY_O=0, WRITE_PTR_O unchanged while VALID stays high.
- Drain: from DONE with 255 entries, hold READ_ADVANCE_I -> 255 ACKs on logger turns only, then EMPTY_O=1 and no further ACK.
